// File: rtl/df_dma_walker.sv
// Nested-loop (c outer, y inner) DMA address sequencer: walks one tile descriptor
// and emits burst requests of at most MAX_BURST_B bytes with a valid/ready handshake.
module df_dma_walker #(
    parameter int ADDR_W      = 32,
    parameter int MAX_BURST_B = 64,
    parameter int LEN_W       = $clog2(MAX_BURST_B) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [23:0]       i_ett,
    input  logic [11:0]       i_y_step,
    input  logic [11:0]       i_y_lim,
    input  logic [23:0]       i_c_step,
    input  logic [23:0]       i_c_lim,
    output logic              o_req_valid,
    input  logic              i_req_ready,
    output logic [ADDR_W-1:0] o_req_addr,
    output logic [LEN_W-1:0]  o_req_len,
    output logic              o_req_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [23:0] MAX_B = 24'(MAX_BURST_B);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_base;
    logic [23:0]       r_ett;
    logic [11:0]       r_yStep;
    logic [11:0]       r_yLim;
    logic [23:0]       r_cStep;
    logic [23:0]       r_cLim;
    logic [23:0]       r_bOff;
    logic [11:0]       r_yOff;
    logic [23:0]       r_cOff;
    logic              r_err;

    logic              w_valid;
    logic              w_fire;
    logic              w_startOk;
    logic [23:0]       w_remain;
    logic [LEN_W-1:0]  w_len;
    logic              w_chunkEnd;
    logic [12:0]       w_yNext;
    logic              w_yWrap;
    logic [24:0]       w_cNext;
    logic              w_cEnd;
    logic              w_last;
    logic [25:0]       w_offSum;
    logic [ADDR_W-1:0] w_addr;

    assign w_valid   = (r_state == REQ);
    assign w_fire    = w_valid && i_req_ready;
    assign w_startOk = i_start && (i_ett != 24'd0) && (r_state != REQ);

    assign w_remain   = r_ett - r_bOff;
    assign w_len      = (w_remain > MAX_B) ? LEN_W'(MAX_BURST_B) : LEN_W'(w_remain);
    assign w_chunkEnd = (w_remain <= MAX_B);

    // Limits are compared one bit wider so a stride that overflows the field still terminates the loop.
    assign w_yNext = {1'b0, r_yOff} + {1'b0, r_yStep};
    assign w_yWrap = (r_yStep == 12'd0) || (w_yNext >= {1'b0, r_yLim});
    assign w_cNext = {1'b0, r_cOff} + {1'b0, r_cStep};
    assign w_cEnd  = (r_cStep == 24'd0) || (w_cNext >= {1'b0, r_cLim});
    assign w_last  = w_chunkEnd && w_yWrap && w_cEnd;

    assign w_offSum = 26'(r_cOff) + 26'(r_yOff) + 26'(r_bOff);
    assign w_addr   = r_base + ADDR_W'(w_offSum);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, DONE: w_nextState = w_startOk ? REQ : IDLE;
            REQ: begin
                if (i_abort) begin
                    w_nextState = IDLE;
                end else if (w_fire && w_last) begin
                    w_nextState = DONE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_base  <= '0;
            r_ett   <= '0;
            r_yStep <= '0;
            r_yLim  <= '0;
            r_cStep <= '0;
            r_cLim  <= '0;
            r_bOff  <= '0;
            r_yOff  <= '0;
            r_cOff  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= i_start && (i_ett == 24'd0) && (r_state != REQ);
            if (w_startOk) begin
                r_base  <= i_base;
                r_ett   <= i_ett;
                r_yStep <= i_y_step;
                r_yLim  <= i_y_lim;
                r_cStep <= i_c_step;
                r_cLim  <= i_c_lim;
                r_bOff  <= '0;
                r_yOff  <= '0;
                r_cOff  <= '0;
            end else if (w_fire && !i_abort) begin
                if (!w_chunkEnd) begin
                    r_bOff <= r_bOff + 24'(w_len);
                end else begin
                    r_bOff <= '0;
                    if (!w_yWrap) begin
                        r_yOff <= w_yNext[11:0];
                    end else begin
                        r_yOff <= '0;
                        if (!w_cEnd) begin
                            r_cOff <= w_cNext[23:0];
                        end
                    end
                end
            end
        end
    end

    // Request fields are held at zero outside a walk so idle outputs match reset.
    assign o_req_valid = w_valid;
    assign o_req_addr  = w_valid ? w_addr : '0;
    assign o_req_len   = w_valid ? w_len : '0;
    assign o_req_last  = w_valid && w_last;
    assign o_busy      = w_valid;
    assign o_done      = (r_state == DONE);
    assign o_err       = r_err;

endmodule

// File: tb/tb_df_dma_walker.sv
// Self-checking bench for df_dma_walker: a request-list model built from nested
// loops predicts every cycle's outputs; directed walks pin the model with literals.
module tb_df_dma_walker;

    localparam int MAXB = 64;

    typedef struct {
        logic [31:0] addr;
        logic [6:0]  len;
        logic        last;
    } req_t;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic        i_abort;
    logic [31:0] i_base;
    logic [23:0] i_ett;
    logic [11:0] i_y_step;
    logic [11:0] i_y_lim;
    logic [23:0] i_c_step;
    logic [23:0] i_c_lim;
    logic        o_req_valid;
    logic        i_req_ready;
    logic [31:0] o_req_addr;
    logic [6:0]  o_req_len;
    logic        o_req_last;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int   errors;
    int   checks;
    int   errSeen;
    bit   readyRandom;
    req_t mQ[$];
    req_t obs[$];
    bit   mActive;
    bit   mDone;
    bit   mErr;
    bit   nDone;
    bit   nErr;
    req_t obsItem;

    df_dma_walker #(.ADDR_W(32), .MAX_BURST_B(MAXB)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_start(i_start),
        .i_abort(i_abort),
        .i_base(i_base),
        .i_ett(i_ett),
        .i_y_step(i_y_step),
        .i_y_lim(i_y_lim),
        .i_c_step(i_c_step),
        .i_c_lim(i_c_lim),
        .o_req_valid(o_req_valid),
        .i_req_ready(i_req_ready),
        .o_req_addr(o_req_addr),
        .o_req_len(o_req_len),
        .o_req_last(o_req_last),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_err(o_err)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // The whole walk as a flat list: c outer, y inner, chunk split into bursts.
    function automatic void buildWalk(input logic [31:0] base, input longint ett,
                                      input longint ys, input longint yl,
                                      input longint cs, input longint cl);
        longint c;
        longint y;
        longint b;
        req_t   r;
        c = 0;
        while (1'b1) begin
            y = 0;
            while (1'b1) begin
                b = 0;
                while (b < ett) begin
                    r.addr = 32'(longint'(base) + c + y + b);
                    r.len  = 7'((ett - b > MAXB) ? MAXB : (ett - b));
                    r.last = 1'b0;
                    mQ.push_back(r);
                    b += MAXB;
                end
                if (ys == 0 || y + ys >= yl) break;
                y += ys;
            end
            if (cs == 0 || c + cs >= cl) break;
            c += cs;
        end
        mQ[mQ.size() - 1].last = 1'b1;
    endfunction

    // Compare on the falling edge, then advance the model using the inputs the DUT will see next edge.
    always @(negedge i_clk) begin
        if (i_rst) begin
            mQ.delete();
            mActive = 1'b0;
            mDone   = 1'b0;
            mErr    = 1'b0;
        end else begin
            checkOutput("valid", o_req_valid, mActive);
            checkOutput("busy", o_busy, mActive);
            checkOutput("done", o_done, mDone);
            checkOutput("err", o_err, mErr);
            if (mActive && mQ.size() > 0) begin
                checkOutput("addr", o_req_addr, mQ[0].addr);
                checkOutput("len", o_req_len, mQ[0].len);
                checkOutput("last", o_req_last, mQ[0].last);
            end
            if (o_err) errSeen++;
            if (o_req_valid && i_req_ready) begin
                obsItem.addr = o_req_addr;
                obsItem.len  = o_req_len;
                obsItem.last = o_req_last;
                obs.push_back(obsItem);
            end
            nDone = 1'b0;
            nErr  = 1'b0;
            if (mActive) begin
                if (i_abort) begin
                    mQ.delete();
                    mActive = 1'b0;
                end else if (i_req_ready && mQ.size() > 0) begin
                    void'(mQ.pop_front());
                    if (mQ.size() == 0) begin
                        mActive = 1'b0;
                        nDone   = 1'b1;
                    end
                end
            end else if (i_start) begin
                if (i_ett == 24'd0) begin
                    nErr = 1'b1;
                end else begin
                    buildWalk(i_base, longint'(i_ett), longint'(i_y_step), longint'(i_y_lim),
                              longint'(i_c_step), longint'(i_c_lim));
                    mActive = 1'b1;
                end
            end
            mDone = nDone;
            mErr  = nErr;
        end
    end

    initial begin
        i_req_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            i_req_ready = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Called 1 time unit after a rising edge; returns at the same phase with i_start low.
    task automatic applyStimulus(input logic [31:0] base, input logic [23:0] ett,
                                 input logic [11:0] ys, input logic [11:0] yl,
                                 input logic [23:0] cs, input logic [23:0] cl);
        i_base   = base;
        i_ett    = ett;
        i_y_step = ys;
        i_y_lim  = yl;
        i_c_step = cs;
        i_c_lim  = cl;
        i_start  = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic waitIdle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            @(posedge i_clk);
            #1;
            if (!mActive && !o_busy && !o_done) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("walkTimeout", ok, 1);
    endtask

    task automatic checkBasicLog(input string tag);
        logic [31:0] expA[4];
        expA = '{32'h8000_0000, 32'h8000_0100, 32'h8000_1000, 32'h8000_1100};
        checkOutput({tag, "Count"}, obs.size(), 4);
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            checkOutput({tag, "Addr"}, obs[i].addr, expA[i]);
            checkOutput({tag, "Len"}, obs[i].len, 64);
            checkOutput({tag, "Last"}, obs[i].last, (i == 3) ? 1 : 0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        errSeen = 0;
        readyRandom = 1'b0;
        mActive = 1'b0;
        mDone = 1'b0;
        mErr = 1'b0;
        i_rst = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_base = '0;
        i_ett = '0;
        i_y_step = '0;
        i_y_lim = '0;
        i_c_step = '0;
        i_c_lim = '0;

        #12;
        checkOutput("rstValid", o_req_valid, 0);
        checkOutput("rstBusy", o_busy, 0);
        checkOutput("rstDone", o_done, 0);
        checkOutput("rstErr", o_err, 0);
        checkOutput("rstAddr", o_req_addr, 0);
        checkOutput("rstLen", o_req_len, 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        $display("[TB] basic walk");
        obs.delete();
        applyStimulus(32'h8000_0000, 24'd64, 12'h100, 12'h200, 24'h1000, 24'h2000);
        checkOutput("startLatency", o_req_valid, 1);
        waitIdle();
        checkBasicLog("basic");

        $display("[TB] burst split");
        obs.delete();
        applyStimulus(32'h0000_1000, 24'd150, 12'h0, 12'h0, 24'h0, 24'h0);
        waitIdle();
        checkOutput("splitCount", obs.size(), 3);
        if (obs.size() == 3) begin
            checkOutput("splitA0", obs[0].addr, 32'h1000);
            checkOutput("splitA2", obs[2].addr, 32'h1080);
            checkOutput("splitL1", obs[1].len, 64);
            checkOutput("splitL2", obs[2].len, 22);
        end

        $display("[TB] backpressure");
        readyRandom = 1'b1;
        obs.delete();
        applyStimulus(32'h8000_0000, 24'd64, 12'h100, 12'h200, 24'h1000, 24'h2000);
        waitIdle();
        checkBasicLog("bp");
        readyRandom = 1'b0;

        $display("[TB] degenerate inputs");
        obs.delete();
        applyStimulus(32'h0000_4000, 24'd64, 12'h0, 12'h200, 24'h0, 24'h0);
        waitIdle();
        checkOutput("yStep0Count", obs.size(), 1);
        errSeen = 0;
        applyStimulus(32'h0000_4000, 24'd0, 12'h10, 12'h20, 24'h0, 24'h0);
        checkOutput("ettZeroBusy", o_busy, 0);
        checkOutput("ettZeroErr", o_err, 1);
        waitIdle();
        checkOutput("ettZeroPulses", errSeen, 1);
        checkOutput("ettZeroCount", obs.size(), 1);

        $display("[TB] abort and restart");
        applyStimulus(32'h8000_0000, 24'd64, 12'h100, 12'h200, 24'h1000, 24'h2000);
        @(posedge i_clk);
        #1;
        checkOutput("abortOn2nd", o_req_addr, 32'h8000_0100);
        i_abort = 1'b1;
        @(posedge i_clk);
        #1;
        i_abort = 1'b0;
        checkOutput("abortValid", o_req_valid, 0);
        checkOutput("abortBusy", o_busy, 0);
        checkOutput("abortNoDone", o_done, 0);
        @(posedge i_clk);
        #1;
        checkOutput("abortNoDoneLater", o_done, 0);
        obs.delete();
        applyStimulus(32'h8000_0000, 24'd64, 12'h100, 12'h200, 24'h1000, 24'h2000);
        waitIdle();
        checkBasicLog("restart");

        $display("[TB] wrap");
        obs.delete();
        applyStimulus(32'hFFFF_FFC0, 24'd128, 12'h0, 12'h0, 24'h0, 24'h0);
        waitIdle();
        checkOutput("wrapCount", obs.size(), 2);
        if (obs.size() == 2) begin
            checkOutput("wrapA0", obs[0].addr, 32'hFFFF_FFC0);
            checkOutput("wrapA1", obs[1].addr, 32'h0000_0000);
        end

        $display("[TB] start in done cycle");
        obs.delete();
        applyStimulus(32'h0000_2000, 24'd32, 12'h0, 12'h0, 24'h0, 24'h0);
        @(posedge i_clk);
        #1;
        checkOutput("doneCycle", o_done, 1);
        applyStimulus(32'h0000_3000, 24'd16, 12'h0, 12'h0, 24'h0, 24'h0);
        waitIdle();
        checkOutput("doneRestartCount", obs.size(), 2);
        if (obs.size() == 2) begin
            checkOutput("doneRestartAddr", obs[1].addr, 32'h3000);
        end

        $display("[TB] reset mid-walk");
        applyStimulus(32'h8000_0000, 24'd200, 12'h40, 12'h100, 24'h0, 24'h0);
        @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        checkOutput("midRstValid", o_req_valid, 0);
        checkOutput("midRstBusy", o_busy, 0);
        checkOutput("midRstDone", o_done, 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        $display("[TB] randomized walks");
        readyRandom = 1'b1;
        for (int t = 0; t < 30; t++) begin
            logic [11:0] ys;
            logic [23:0] cs;
            ys = ($urandom_range(0, 3) == 0) ? 12'h0 : 12'($urandom_range(1, 128));
            cs = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom_range(1, 4096));
            applyStimulus($urandom, 24'($urandom_range(1, 200)), ys,
                          12'($urandom_range(0, 512)),
                          cs, 24'($urandom_range(0, (cs == 0) ? 8192 : 3 * int'(cs))));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 3)) @(posedge i_clk);
                i_ett = 24'($urandom_range(0, 100));
                i_base = $urandom;
                i_start = 1'b1;
                @(posedge i_clk);
                #1;
                i_start = 1'b0;
            end
            waitIdle();
        end
        readyRandom = 1'b0;

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
